// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state and step-mode definitions for the lab counters
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_t;

  localparam logic MODE_DEC  = 1'b0;
  localparam logic MODE_HALF = 1'b1;

endpackage

// File: rtl/counter_dnld.sv
// rtl/counter_dnld.sv - loadable down-counter/timer with terminal-count pulse and auto-reload
module counter_dnld
  import counter_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         start,
  input  logic [N-1:0] load_value,
  input  logic         mode,
  input  logic         auto_reload,
  output logic [N-1:0] counter,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  cnt_state_t   state_q, state_d;
  logic [N-1:0] counter_q, counter_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;
  logic [N-1:0] step_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
    end
  end

  // counter_q is never zero in RUN, so the decrement cannot wrap
  always_comb begin
    step_val  = (mode == MODE_HALF) ? (counter_q >> 1) : (counter_q - ONE);
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (load_value != '0) begin
            counter_d = load_value;
            reload_d  = load_value;
            state_d   = RUN;
          end else begin
            counter_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      RUN: begin
        if (start) begin
          counter_d = load_value;
          reload_d  = load_value;
          if (load_value == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (enable) begin
          if (step_val != '0) begin
            counter_d = step_val;
          end else if (auto_reload) begin
            counter_d = reload_q;
            done_d    = 1'b1;
          end else begin
            counter_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    counter = counter_q;
    busy    = (state_q == RUN);
    done    = done_q;
  end

endmodule

// File: doc/counter_dnld.md
# counter_dnld

Loadable down-counter/timer with enable, the decrementing counterpart of the team's doubling counter. Each enabled step either subtracts one or halves the count, so values shrink toward zero instead of growing. It raises a one-cycle `done` pulse at terminal count and can optionally auto-reload. It sits beside the lab counters as a programmable interval/pulse generator driven by the same `clk`/`reset`/`enable` scheme.

## Interface
- `N`, default 5: counter width in bits.

- `clk` input 1: system clock, all logic on posedge.
- `reset` input 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `enable` input 1: when 1 in RUN, perform one count step.
- `start` input 1: load `load_value` and begin a run.
- `load_value` input N: start/reload value, sampled on `start`.
- `mode` input 1: step type; 0 = decrement by 1, 1 = halve (logical shift right by 1).
- `auto_reload` input 1: 1 = reload at terminal count and keep running; 0 = stop at zero.
- `counter` output N: current count, registered.
- `busy` output 1: 1 while in RUN.
- `done` output 1: registered one-cycle pulse at terminal count.

## Operation
- States: IDLE, RUN.
- Reset, which has the highest priority: `counter`=0, `busy`=0, `done`=0, internal reload register = 0, state = IDLE.
- `done` defaults to 0 every cycle unless set by a rule below.
- IDLE:
  - `start`=1 and `load_value`≠0: `counter`←`load_value`, reload register ← `load_value`, go to RUN, `busy`←1.
  - `start`=1 and `load_value`=0: stay in IDLE, `counter`←0, `done`←1 (immediate terminal).
  - `enable` is ignored in IDLE.
- RUN, priority order:
  - `start`=1: restart. `counter`←`load_value` and reload register updated. No `done`. The enable step is suppressed.
    - If `load_value`=0, go to IDLE with `done`←1.
  - Otherwise, `enable`=0: hold all state.
  - Otherwise, `enable`=1: next = `counter`−1 (mode 0) or `counter`>>1 (mode 1).
    - If next ≠ 0: `counter`←next.
    - If next = 0 and `auto_reload`=1: `counter`←reload register (0 is never visible), `done`←1, stay in RUN.
    - If next = 0 and `auto_reload`=0: `counter`←0, `done`←1, go to IDLE, `busy`←0.
- `mode` and `auto_reload` are sampled at every step, so changing them mid-run is legal.
- Arithmetic is unsigned N-bit. In RUN `counter` is ≥1, so decrement never underflows.

## Timing
- All outputs are registered. `done` is high for exactly the cycle after the edge where terminal count is reached.
  - Without reload, that cycle coincides with `counter`=0 and `busy`=0.
- Latency from a `start` edge to the first step: the first eligible `enable` is on the next edge.
- Mode 0 from L: terminal count after exactly L enabled cycles. In auto-reload the period is L enabled cycles.
- Mode 1 from L: terminal count after floor(log2 L)+1 enabled cycles.
- `start` and `enable` in the same cycle: load only, no step.
- `reset` mid-run: everything returns to reset values on that edge, with no `done` pulse.

## Structure
- Shared package `counter_pkg`:
  - state enum `cnt_state_t` {IDLE, RUN}.
  - mode constants `MODE_DEC`=1'b0 and `MODE_HALF`=1'b1.
- No sub-module. The step/next-value logic is an inline combinational block feeding a single sequential always block.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles with random inputs -> `counter`=0, `busy`=0, `done`=0. `enable` pulses while IDLE leave `counter` at 0.
- Decrement, no reload: N=5, `start` with `load_value`=5, `mode`=0, `enable`=1 continuously -> `counter` goes 5,4,3,2,1,0. `done`=1 exactly one cycle, together with `counter`=0 and `busy`=0.
- Halve mode: `load_value`=22, `mode`=1 -> `counter` goes 22,11,5,2,1,0. `done` fires after the 5th enabled cycle.
- Auto-reload with gaps: `load_value`=3, `auto_reload`=1, `enable` toggling 1,0,1,... -> sequence 3,2,1,3,2,1... with held values during `enable`=0. `done` pulses each time 1→3, and `counter` never shows 0.
- Restart and zero load:
  - `start` with `load_value`=9 while `counter`=4 and `enable`=1 -> `counter`=9 next cycle, no step, no `done`.
  - `start` with `load_value`=0 -> IDLE and a single `done` pulse.
- Reset mid-run: assert `reset` while `counter`=2 and `enable`=1 -> all outputs return to reset values on that edge, with no `done`.
